// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: RV32I funct3 encodings, FSM states,
// and helpers for access legality, store byte enables and store lane replication.
package mem_stage_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } mem_state_t;

    // Stores share the load size encoding, so 100/101 behave as byte/half stores.
    function automatic logic access_illegal(input logic [2:0] funct3, input logic [1:0] addr);
        logic illegal;
        case (funct3)
            F3_LB, F3_LBU: illegal = 1'b0;
            F3_LH, F3_LHU: illegal = addr[0];
            F3_LW:         illegal = |addr;
            default:       illegal = 1'b1;
        endcase
        return illegal;
    endfunction

    function automatic logic [3:0] byte_enables(input logic [2:0] funct3, input logic [1:0] addr);
        logic [3:0] be;
        case (funct3[1:0])
            F3_SB[1:0]: be = 4'b0001 << addr;
            F3_SH[1:0]: be = 4'b0011 << addr;
            F3_SW[1:0]: be = 4'b1111;
            default:    be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] funct3, input logic [31:0] data);
        logic [31:0] lanes;
        case (funct3[1:0])
            F3_SB[1:0]: lanes = {4{data[7:0]}};
            F3_SH[1:0]: lanes = {2{data[15:0]}};
            default:    lanes = data;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/load_align_extend.sv
// Combinational load-data aligner: picks the addressed byte/half lane from a bus
// word and sign- or zero-extends it according to the RV32I load funct3.
module load_align_extend
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[7:0];
        case (addr)
            2'd0: byte_lane = rdata[7:0];
            2'd1: byte_lane = rdata[15:8];
            2'd2: byte_lane = rdata[23:16];
            2'd3: byte_lane = rdata[31:24];
            default: byte_lane = rdata[7:0];
        endcase
        half_lane = addr[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_LB:   data = {{24{byte_lane[7]}}, byte_lane};
            F3_LBU:  data = {24'h0, byte_lane};
            F3_LH:   data = {{16{half_lane[15]}}, half_lane};
            F3_LHU:  data = {16'h0, half_lane};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// RV32I memory-access stage: turns EX loads/stores into req/gnt/rvalid bus transactions,
// stalling the front end meanwhile. Define MEM_TIMEOUT_EN to add a bus-wait watchdog.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        ex_memread,
    input  logic        ex_memwrite,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_rd,
    input  logic        ex_regwrite,
    input  logic        ex_memtoreg,
    output logic        regwrite_out,
    output logic        memtoreg_out,
    output logic [31:0] alu_result_out,
    output logic [31:0] mem_data_out,
    output logic [4:0]  rd_out,
    output logic        stall_out,
    output logic        access_fault_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);

    mem_state_t  state;
    mem_state_t  next_state;

    logic [2:0]  hold_funct3;
    logic [31:0] hold_addr;
    logic [31:0] hold_store_data;
    logic [4:0]  hold_rd;
    logic        hold_regwrite;
    logic        hold_memtoreg;
    logic        hold_load;
    logic [31:0] hold_data;

    logic        ex_memop;
    logic        ex_illegal;
    logic        start_access;
    logic        timeout;
    logic [31:0] ext_data;

    assign ex_memop     = ex_valid && (ex_memread || ex_memwrite);
    assign ex_illegal   = access_illegal(ex_funct3, ex_alu_result[1:0]);
    assign start_access = (state == IDLE) && ex_memop && !ex_illegal;

    load_align_extend u_align (
        .rdata  (dmem_rdata),
        .addr   (hold_addr[1:0]),
        .funct3 (hold_funct3),
        .data   (ext_data)
    );

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] wait_cnt;
    logic             bus_wait;
    logic             wait_entry;

    assign bus_wait   = (state == REQ) || (state == WAIT);
    assign wait_entry = ((state == IDLE) && (next_state == REQ)) ||
                        ((state == REQ) && (next_state == WAIT));
    assign timeout    = bus_wait && (wait_cnt == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (wait_entry) begin
            wait_cnt <= '0;
        end else if (bus_wait) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Both memread and memwrite set counts as a load.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_funct3     <= '0;
            hold_addr       <= '0;
            hold_store_data <= '0;
            hold_rd         <= '0;
            hold_regwrite   <= 1'b0;
            hold_memtoreg   <= 1'b0;
            hold_load       <= 1'b0;
            hold_data       <= '0;
        end else if (start_access) begin
            hold_funct3     <= ex_funct3;
            hold_addr       <= ex_alu_result;
            hold_store_data <= ex_store_data;
            hold_rd         <= ex_rd;
            hold_regwrite   <= ex_regwrite;
            hold_memtoreg   <= ex_memtoreg;
            hold_load       <= ex_memread;
            hold_data       <= '0;
        end else if ((state == WAIT) && (next_state == DONE)) begin
            hold_data       <= ext_data;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (start_access) next_state = REQ;
            REQ: begin
                if (timeout)       next_state = IDLE;
                else if (dmem_gnt) next_state = hold_load ? WAIT : DONE;
            end
            WAIT: begin
                if (timeout)          next_state = IDLE;
                else if (dmem_rvalid) next_state = DONE;
            end
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are forced low while reset is held, since IDLE is otherwise a pass-through.
    always_comb begin
        regwrite_out     = 1'b0;
        memtoreg_out     = 1'b0;
        alu_result_out   = '0;
        mem_data_out     = '0;
        rd_out           = '0;
        stall_out        = 1'b0;
        access_fault_out = 1'b0;
        dmem_req         = 1'b0;
        dmem_we          = 1'b0;
        dmem_be          = '0;
        dmem_addr        = '0;
        dmem_wdata       = '0;
        if (!reset) begin
            unique case (state)
                IDLE: begin
                    memtoreg_out   = ex_memtoreg;
                    alu_result_out = ex_alu_result;
                    rd_out         = ex_rd;
                    if (!ex_memop) begin
                        regwrite_out = ex_regwrite && ex_valid;
                    end else if (ex_illegal) begin
                        access_fault_out = 1'b1;
                    end else begin
                        stall_out = 1'b1;
                    end
                end
                REQ: begin
                    memtoreg_out   = hold_memtoreg;
                    alu_result_out = hold_addr;
                    rd_out         = hold_rd;
                    if (timeout) begin
                        access_fault_out = 1'b1;
                    end else begin
                        stall_out  = 1'b1;
                        dmem_req   = 1'b1;
                        dmem_we    = !hold_load;
                        dmem_be    = byte_enables(hold_funct3, hold_addr[1:0]);
                        dmem_addr  = {hold_addr[31:2], 2'b00};
                        dmem_wdata = hold_load ? 32'h0 : store_lanes(hold_funct3, hold_store_data);
                    end
                end
                WAIT: begin
                    memtoreg_out   = hold_memtoreg;
                    alu_result_out = hold_addr;
                    rd_out         = hold_rd;
                    if (timeout) begin
                        access_fault_out = 1'b1;
                    end else begin
                        stall_out = 1'b1;
                    end
                end
                DONE: begin
                    regwrite_out   = hold_regwrite && hold_load;
                    memtoreg_out   = hold_memtoreg;
                    alu_result_out = hold_addr;
                    rd_out         = hold_rd;
                    mem_data_out   = hold_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access stage of the RISC-V pipeline, between EX and the EX/WB pipeline register.
- Converts EX load/store requests into a req/gnt/rvalid data-bus transaction and stalls the front of the pipeline until the access completes.
- Aligns and sign/zero-extends load data.
- Presents regwrite/memtoreg/alu_result/mem_data/rd to the EX/WB register.

Parameters:
- TIMEOUT_CYCLES, 255: watchdog limit for bus waits. Used only with MEM_TIMEOUT_EN.

Ports:
- clock  input  1  stage clock
- reset  input  1  asynchronous, active-high reset
- ex_valid  input  1  EX stage holds a valid instruction
- ex_memread  input  1  instruction is a load
- ex_memwrite  input  1  instruction is a store
- ex_funct3  input  3  access size/sign (RV32I encoding)
- ex_alu_result  input  32  effective address, or ALU result for non-memory ops
- ex_store_data  input  32  rs2 value for stores
- ex_rd  input  5  destination register
- ex_regwrite  input  1  writeback enable
- ex_memtoreg  input  1  select memory data at WB
- regwrite_out  output  1  to EX/WB register
- memtoreg_out  output  1  to EX/WB register
- alu_result_out  output  32  to EX/WB register
- mem_data_out  output  32  extended load data
- rd_out  output  5  to EX/WB register
- stall_out  output  1  freeze PC/IF/ID/EX
- access_fault_out  output  1  misaligned/illegal access, one-cycle pulse
- dmem_req  output  1  bus request
- dmem_we  output  1  1 = write
- dmem_be  output  4  byte enables
- dmem_addr  output  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata  output  32  lane-replicated store data
- dmem_gnt  input  1  request accepted
- dmem_rvalid  input  1  read data valid
- dmem_rdata  input  32  read data

Behaviour:
- Reset, asynchronous: state=IDLE; holding registers cleared; dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0, stall_out=0, access_fault_out=0, regwrite_out=0, memtoreg_out=0, alu_result_out=0, mem_data_out=0, rd_out=0.
- States: IDLE, REQ, WAIT, DONE.
- IDLE, no memory op (ex_valid=0, or memread=memwrite=0): pass-through. Outputs combinationally equal the ex_* inputs, gated as regwrite_out=ex_regwrite&ex_valid. mem_data_out=0. stall_out=0.
- IDLE, legal memory op:
  - Capture funct3, address, store data, rd, regwrite, memtoreg and memread into holding registers.
  - Assert stall_out combinationally; regwrite_out=0 (bubble).
  - Next state REQ.
- IDLE, illegal memory op: no bus access, no stall, access_fault_out=1 for one cycle, regwrite_out=0. Illegal means:
  - lw/sw with addr[1:0]!=0;
  - lh/lhu/sh with addr[0]!=0;
  - funct3 of 011, 110 or 111.
- REQ:
  - dmem_req=1, driven from the holding registers. Bus signals stay stable until gnt.
  - stall_out=1, regwrite_out=0.
  - On gnt: a store goes to DONE; a load goes to WAIT.
  - rvalid in REQ is ignored.
- WAIT:
  - dmem_req=0, stall_out=1.
  - On rvalid: capture the extended rdata into mem_data and go to DONE.
- DONE:
  - stall_out=0.
  - Outputs are taken from the holding registers: regwrite_out=held regwrite (0 for stores); mem_data_out=held data.
  - Next state IDLE unconditionally. The following instruction appears in the next cycle.
- Store byte enables and data:
  - sb: be = 1<<addr[1:0]; wdata = {4{data[7:0]}}.
  - sh: be = 4'b0011<<addr[1:0]; wdata = {2{data[15:0]}}.
  - sw: be = 4'b1111.
- Load extension: select the lane by addr[1:0].
  - lb/lh: sign-extend.
  - lbu/lhu: zero-extend.
  - lw: pass through.
- Latency: store min 2 stall cycles + DONE; load min 3 stall cycles + DONE (gnt in first REQ cycle, rvalid in the next).
- Memory op with ex_memread=ex_memwrite=1: treated as a load.
- rvalid in IDLE or DONE (e.g. a stale response after reset): ignored.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined: an 8+-bit counter clears on entry to REQ and on entry to WAIT, and increments every cycle spent in REQ or WAIT. When it reaches TIMEOUT_CYCLES:
  - dmem_req drops;
  - access_fault_out pulses for one cycle;
  - regwrite_out=0;
  - state goes to IDLE, releasing the stall.
- Undefined: no counter; REQ/WAIT wait indefinitely.

Decomposition:
- Package mem_stage_pkg:
  - funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, F3_SB, F3_SH, F3_SW;
  - state enum;
  - default TIMEOUT_CYCLES.
- Sub-module load_align_extend: combinational; inputs rdata, addr[1:0], funct3; output 32-bit extended data.

Test Plan:
- ALU op, ex_alu_result=0x1234, rd=5, regwrite=1 -> same-cycle pass-through, stall_out=0, no dmem_req.
- sb addr=0x1003, data=0xA5 -> dmem_addr=0x1000, be=4'b1000, wdata=0xA5A5A5A5, we=1; gnt after 2 cycles -> stall released in DONE, regwrite_out=0.
- lb addr=0x2001, rdata=0x0000_8000, rvalid 3 cycles after gnt -> mem_data_out=0xFFFFFF80 in DONE, memtoreg_out=1, rd_out matches.
- lhu addr=0x2002, rdata=0xBEEF_0000 -> mem_data_out=0x0000BEEF.
- lw addr=0x3002 -> access_fault_out pulse, dmem_req never asserted, stall_out=0.
- Reset asserted in WAIT, then rvalid arrives -> immediate return to IDLE, dmem_req=0, rvalid ignored. With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, gnt held low -> fault pulse after 4 REQ cycles.
